// File: rtl/receive_pkg.sv
// receive_pkg: shared definitions for the UART receive controller.
//   CNT_W         - bit-time counter width
//   BIT_W         - bit counter width
//   state_t       - receive FSM state encoding
//   baud_full_cnt - baud index to full bit time, in clk cycles
package receive_pkg;

  localparam int CNT_W = 19;
  localparam int BIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] baud_full_cnt(input logic [3:0] idx);
    logic [CNT_W-1:0] cnt;
    case (idx)
      4'd0:    cnt = 19'd333333;
      4'd1:    cnt = 19'd83333;
      4'd2:    cnt = 19'd41667;
      4'd3:    cnt = 19'd20833;
      4'd4:    cnt = 19'd10417;
      4'd5:    cnt = 19'd5208;
      4'd6:    cnt = 19'd2604;
      4'd7:    cnt = 19'd1736;
      4'd8:    cnt = 19'd868;
      4'd9:    cnt = 19'd434;
      4'd10:   cnt = 19'd217;
      4'd11:   cnt = 19'd109;
      default: cnt = 19'd868;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/baud_decoder.sv
// baud_decoder: combinational baud index to full bit time lookup.
//   baud_idx - 4-bit baud-rate select index
//   full_cnt - full bit time in clk cycles
module baud_decoder
  import receive_pkg::*;
(
  input  logic [3:0]       baud_idx,
  output logic [CNT_W-1:0] full_cnt
);

  always_comb begin
    full_cnt = baud_full_cnt(baud_idx);
  end

endmodule

// File: rtl/receive_control.sv
// receive_control: UART receive sequencing (start detect, bit timing, frame end).
//   clk    - system clock
//   reset  - synchronous active-high reset
//   rx     - asynchronous serial line, idle high
//   baud   - baud-rate select index, latched at frame start
//   eight  - 1 = 8 data bits, 0 = 7 data bits, latched at frame start
//   pen    - parity enable, latched at frame start
//   rx_s   - synchronized rx for the datapath shifter
//   start  - high while in START
//   BTU    - one-cycle bit-time-up pulse
//   done   - one-cycle frame-complete pulse
//   done_d - done delayed one clock
//
// state    | meaning
// ST_IDLE  | line idle, counters cleared, waiting for rx_s low
// ST_START | timing half a bit to the middle of the start bit
// ST_DATA  | timing full bits through data, parity and stop
module receive_control
  import receive_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       pen,
  output logic       rx_s,
  output logic       start,
  output logic       BTU,
  output logic       done,
  output logic       done_d
);

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [3:0]       baud_q, baud_d;
  logic             eight_q, eight_d;
  logic             pen_q, pen_d;
  logic             done_dly_q, done_dly_d;

  logic [CNT_W-1:0] full_cnt;
  logic [CNT_W-1:0] half_cnt;
  logic [BIT_W-1:0] frame_len;
  logic [BIT_W-1:0] bit_inc;
  logic             btu_c;
  logic             done_c;

  // Decode from the latched index so a baud change mid-frame has no effect.
  baud_decoder u_baud_decoder (
    .baud_idx (baud_q),
    .full_cnt (full_cnt)
  );

  always_comb begin
    half_cnt  = full_cnt >> 1;
    // Data bits plus optional parity plus one stop bit.
    frame_len = BIT_W'(8) + BIT_W'(eight_q) + BIT_W'(pen_q);
    bit_inc   = bit_q + BIT_W'(1);

    sync1_d    = rx;
    rx_s_d     = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    baud_d     = baud_q;
    eight_d    = eight_q;
    pen_d      = pen_q;
    btu_c      = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) begin
          state_d = ST_START;
          baud_d  = baud;
          eight_d = eight;
          pen_d   = pen;
        end
      end
      ST_START: begin
        if (cnt_q == half_cnt - CNT_W'(1)) begin
          btu_c   = 1'b1;
          cnt_d   = '0;
          // Line back high at mid start bit means a glitch, not a frame.
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == full_cnt - CNT_W'(1)) begin
          btu_c = 1'b1;
          cnt_d = '0;
          if (bit_inc == frame_len) begin
            done_c  = 1'b1;
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_inc;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    done_dly_d = done_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      baud_q     <= '0;
      eight_q    <= 1'b0;
      pen_q      <= 1'b0;
      done_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      eight_q    <= eight_d;
      pen_q      <= pen_d;
      done_dly_q <= done_dly_d;
    end
  end

  assign rx_s   = rx_s_q;
  assign start  = (state_q == ST_START);
  assign BTU    = btu_c;
  assign done   = done_c;
  assign done_d = done_dly_q;

endmodule

// File: tb/tb_receive_control.sv
// tb_receive_control: directed bench for receive_control with a BTU scoreboard.
module tb_receive_control;
  import receive_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] baud;
  logic       eight;
  logic       pen;
  logic       rx_s, start, BTU, done, done_d;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    int   cyc;
    logic start;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  int full_tbl[16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                       868, 434, 217, 109, 868, 868, 868, 868};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  receive_control dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .baud   (baud),
    .eight  (eight),
    .pen    (pen),
    .rx_s   (rx_s),
    .start  (start),
    .BTU    (BTU),
    .done   (done),
    .done_d (done_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every BTU must match the next expected event.
  logic prev_done = 1'b0;
  logic prev_btu  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    chk("done_d_follows_done", 32'(done_d), 32'(prev_done));
    if (BTU === 1'b1) begin
      chk("btu_not_back_to_back", 32'(prev_btu), 32'd0);
      chk("btu_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("btu_cycle", 32'(cyc), 32'(e.cyc));
        chk("btu_start", 32'(start), 32'(e.start));
        chk("btu_done", 32'(done), 32'(e.done));
      end
    end else begin
      chk("done_only_with_btu", 32'(done), 32'd0);
    end
    prev_done = done;
    prev_btu  = BTU;
  end

  // Start BTU lands half+2 cycles after the falling edge (2 sync flops + IDLE exit).
  task automatic push_frame(input int fall, input int full, input int n, input int n_push);
    exp_t e;
    int   t;
    t       = fall + full / 2 + 2;
    e.cyc   = t;
    e.start = 1'b1;
    e.done  = 1'b0;
    exp_q.push_back(e);
    for (int k = 1; k <= n_push; k++) begin
      e.cyc   = t + k * full;
      e.start = 1'b0;
      e.done  = (k == n);
      exp_q.push_back(e);
    end
  endtask

  // Drives start + data/parity bits, then holds the line high until done.
  task automatic send_frame(input logic [3:0] b, input logic e8, input logic pe,
                            input logic [9:0] bits, input int chg_baud,
                            output int done_cyc);
    int full;
    int nb;
    full  = full_tbl[b];
    nb    = 7 + int'(e8) + int'(pe);
    baud  = b;
    eight = e8;
    pen   = pe;
    push_frame(cyc, full, nb + 1, nb + 1);
    rx = 1'b0;
    repeat (full) @(negedge clk);
    if (chg_baud >= 0) baud = 4'(chg_baud);
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (full) @(negedge clk);
    end
    rx = 1'b1;
    done_cyc = -1;
    for (int k = 0; k < 2 * full; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("done_within_budget", 32'(done_cyc != -1), 32'd1);
  endtask

  initial begin
    int d0, d1, d2, c0;
    reset = 1'b1;
    rx    = 1'b1;
    baud  = 4'd0;
    eight = 1'b0;
    pen   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_s", 32'(rx_s), 32'd1);
    chk("reset_start", 32'(start), 32'd0);
    chk("reset_btu", 32'(BTU), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_done_d", 32'(done_d), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0x55 at 868 cycles/bit
    send_frame(4'd8, 1'b1, 1'b0, 10'h055, -1, d0);
    @(negedge clk);
    chk("done_d_after_8n1", 32'(done_d), 32'd1);
    repeat (20) @(negedge clk);
    chk("queue_empty_8n1", 32'(exp_q.size()), 32'd0);

    // False start: 200-cycle low glitch at baud 8
    baud = 4'd8;
    c0   = cyc;
    push_frame(c0, 868, 9, 0);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("false_start_in_start", 32'(start), 32'd1);
    repeat (36) @(negedge clk);
    chk("false_start_btu_cycle_start", 32'(start), 32'd1);
    @(negedge clk);
    chk("false_start_start_falls", 32'(start), 32'd0);
    repeat (300) @(negedge clk);
    chk("false_start_no_more_btu", 32'(exp_q.size()), 32'd0);

    // 8P1 at 109 cycles/bit
    send_frame(4'd11, 1'b1, 1'b1, {2'b00, 8'hA5}, -1, d0);
    repeat (20) @(negedge clk);
    chk("queue_empty_8p1", 32'(exp_q.size()), 32'd0);

    // 7N1 at 217 cycles/bit, baud input moved to 0 after the start bit
    send_frame(4'd10, 1'b0, 1'b0, 10'h03C, 0, d0);
    repeat (20) @(negedge clk);
    chk("queue_empty_7n1_baud_change", 32'(exp_q.size()), 32'd0);

    // Reset after the 3rd DATA BTU
    baud  = 4'd11;
    eight = 1'b1;
    pen   = 1'b0;
    c0    = cyc;
    push_frame(c0, 109, 9, 3);
    rx = 1'b0;
    repeat (56 + 3 * 109) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    chk("abort_start", 32'(start), 32'd0);
    chk("abort_btu", 32'(BTU), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_done_d", 32'(done_d), 32'd0);
    chk("abort_rx_s", 32'(rx_s), 32'd1);
    chk("abort_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_more_btu", 32'(exp_q.size()), 32'd0);
    send_frame(4'd11, 1'b1, 1'b0, 10'h00F, -1, d0);
    repeat (20) @(negedge clk);
    chk("queue_empty_after_abort", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second start edge right at the first stop-bit sample
    send_frame(4'd11, 1'b1, 1'b0, 10'h0C3, -1, d1);
    send_frame(4'd11, 1'b1, 1'b0, 10'h03C, -1, d2);
    chk("b2b_spacing_window",
        32'((2 * (d2 - d1) >= 19 * 109 - 4) && (2 * (d2 - d1) <= 19 * 109 + 4)), 32'd1);
    repeat (20) @(negedge clk);
    chk("queue_empty_final", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/receive_control.md
RECEIVE_CONTROL -- requirements
Module: receive_control

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: rx  input  1  asynchronous serial line; idle high.
REQ-004 SHALL have ports: baud  input  4  baud-rate select index.
REQ-005 SHALL have ports: eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 SHALL have ports: pen  input  1  parity enable.
REQ-007 SHALL have ports: rx_s  output  1  synchronized rx, feeding the datapath shift input.
REQ-008 SHALL have ports: start  output  1  high while in START state.
REQ-009 SHALL have ports: BTU  output  1  one-cycle bit-time-up pulse.
REQ-010 SHALL have ports: done  output  1  one-cycle frame-complete pulse.
REQ-011 SHALL have ports: done_d  output  1  done delayed one clock.
REQ-012 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; rx_s is the second flop; all internal decisions use rx_s.
REQ-014 SHALL decode the full bit time in clk cycles from baud as follows:
  - 0: 333333; 1: 83333; 2: 41667; 3: 20833; 4: 10417; 5: 5208
  - 6: 2604; 7: 1736; 8: 868; 9: 434; 10: 217; 11: 109
  - 12-15: 868
REQ-015 Half bit time SHALL equal full >> 1.
REQ-016 baud, eight and pen SHALL be latched on the IDLE->START transition and held constant for the frame.
REQ-017 FSM states: IDLE, START, DATA.
REQ-018 IDLE: counters held at 0; when rx_s == 0, transition to START.
REQ-019 START: the bit-time counter (19-bit) increments each clock; BTU fires when counter == half-1, and the counter returns to 0.
  - At that BTU, if rx_s == 1 (false start), go to IDLE.
  - Otherwise go to DATA.
REQ-020 DATA: the counter increments each clock; BTU fires when counter == full-1, and the counter returns to 0.
  - The bit counter (4-bit) increments on each BTU.
REQ-021 Frame length N = 8 + eight + pen (7N1 = 8, 8N1/7P1 = 9, 8P1 = 10), covering data, parity and stop bits.
REQ-022 On the DATA BTU that makes the bit count equal N:
  - done SHALL assert in that same cycle;
  - the FSM SHALL return to IDLE and the bit counter SHALL clear.
REQ-023 done_d SHALL be done registered one clock, so the datapath samples a fully shifted frame.
REQ-024 start SHALL be asserted combinationally from state == START, including the START-exit BTU cycle; the datapath therefore does not shift on the half-bit BTU.
REQ-025 BTU SHALL be asserted only in START or DATA, and never in two consecutive cycles.
REQ-026 A new frame SHALL NOT be detected in the cycle done asserts; detection resumes from IDLE on the next clock.
REQ-027 rx_s activity during DATA SHALL NOT affect state; error checking belongs downstream.

Reset
REQ-028 On reset:
  - FSM -> IDLE; bit-time and bit counters = 0.
  - Synchronizer flops = 1; rx_s = 1.
  - start = BTU = done = done_d = 0.
  - Latched configuration = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame within one clock, with no done pulse; the next falling edge after reset starts a fresh frame.

Structure
REQ-030 State encodings, the baud-to-count table and the counter widths (19 and 4) SHALL reside in shared package receive_pkg.
REQ-031 The baud table SHALL be implemented in sub-module baud_decoder (4-bit index in, 19-bit full count out, combinational); the FSM and counters stay in receive_control.

Verification
REQ-032 baud=8, eight=1, pen=0, frame 0x55 with stop 1:
  - first BTU 434+2 cycles after the rx falling edge, with start=1;
  - then 9 BTUs spaced 868 cycles;
  - done on the 9th; done_d one cycle later.
REQ-033 rx low for 200 cycles then high, baud=8:
  - START entered; at the half-bit BTU rx_s=1, so the FSM returns to IDLE;
  - no done; start falls after 434 counts.
REQ-034 baud=11, eight=1, pen=1:
  - 10 DATA BTUs spaced 109 cycles;
  - done coincident with the 10th BTU.
REQ-035 baud=4, eight=0, pen=0:
  - 8 DATA BTUs spaced 10417 cycles;
  - changing baud to 0 mid-frame leaves the spacing unchanged.
REQ-036 Reset pulsed after the 3rd DATA BTU:
  - next cycle all outputs are 0 and the state is IDLE;
  - a following frame completes normally with the correct BTU count.
REQ-037 Back-to-back frames (stop bit immediately followed by a start edge):
  - second frame detected;
  - two done pulses separated by (N+0.5)*full cycles, ±2.
